div16_seq_led: RTL and testbench
================================

// Module: div16_seq_led
// PURPOSE
// - Sequential 16-bit unsigned integer divider (restoring, one quotient bit per clock).
// - Combinational 4-digit hex seven-segment encoder driven by the quotient.
// - Sits between the operand/start source and the board's 4-digit LED display.
// PARAMETERS
// - none (widths fixed: 16-bit operands, 4 digits x 7 segments)
// PORTS
// clk        in   1   system clock, all state on rising edge
// rst        in   1   asynchronous, active-low reset (0 = reset)
// start      in   1   one-cycle pulse; latch a,b and begin division
// a          in   16  dividend (unsigned)
// b          in   16  divisor (unsigned)
// done       out  1   high when y/remainder hold a completed result
// y          out  16  quotient
// remainder  out  16  remainder
// out1       out  7   hex digit y[15:12], segments {g,f,e,d,c,b,a}, active-low
// out2       out  7   hex digit y[11:8]
// out3       out  7   hex digit y[7:4]
// out4       out  7   hex digit y[3:0]
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, done=0, y=0, remainder=0, internal regs=0.
// - Reset mid-operation: aborts immediately; no partial result ever appears.
// - FSM: IDLE -(start=1)-> CALC -(16 iterations)-> DONE -(start=1)-> CALC.
// - IDLE/DONE: start sampled on clk edge; a,b latched that edge; done cleared.
// - CALC: restoring step per cycle: R={R[14:0],Q[15]}; Q<<=1;
//   if R>=B then R-=B, Q[0]=1. 17-bit compare/subtract, no overflow.
// - Latency: start sampled at edge N -> done=1, y, remainder valid at edge N+17.
// - done sticky high in DONE until next accepted start or reset.
// - start while in CALC is ignored; a,b changes after latch have no effect.
// - y/remainder update only on entry to DONE; hold last result otherwise.
// - b=0: y=16'hFFFF, remainder=a, same 17-cycle latency, done asserted.
// - a<b: y=0, remainder=a. a=0: y=0, remainder=0.
// - Invariant: y*b+remainder==a and remainder<b (b!=0).
// - Encoder: purely combinational from y; codes (hex 0..F):
//   0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//   6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011
//   C=1000110 d=0100001 E=0000110 F=0001110
// - After reset y=0 -> all four digits show 1000000.
// TESTING
// - a=110,b=25, start pulse -> done at +17 edges; y=4, remainder=10;
//   out4=0011001, out1..out3=1000000.
// - a=32200,b=37 -> y=870 (0x0366), remainder=10; out1=1000000,
//   out2=0110000, out3=0000010, out4=0000010.
// - a=1234,b=56 -> y=22 (0x0016), remainder=2; out3=1111001, out4=0000010.
// - a=500,b=0 -> y=16'hFFFF, remainder=500, done=1; all digits 0001110.
// - Second start during CALC (a=9,b=3) ignored -> first result delivered;
//   start after done -> new result 3 r0 at +17 edges.
// - rst=0 at cycle 8 of CALC -> done=0, y=0, remainder=0 immediately;
//   after release, new start completes normally.

Source files
------------

// File: rtl/div16_seq_led.sv
// Sequential 16-bit unsigned restoring divider, one quotient bit per clock,
// with a combinational 4-digit active-low hex seven-segment view of the quotient.
module div16_seq_led (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        done,
  output logic [15:0] y,
  output logic [15:0] remainder,
  output logic [6:0]  out1,
  output logic [6:0]  out2,
  output logic [6:0]  out3,
  output logic [6:0]  out4
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [W-1:0]   rq, rq_nxt;
  logic [W-1:0]   qq, qq_nxt;
  logic [W-1:0]   bq, bq_nxt;
  logic           done_nxt;
  logic [W-1:0]   y_nxt, rem_nxt;

  logic [W:0]     shifted;
  logic           ge;
  logic [W-1:0]   sub;
  logic           last;

  // One restoring step; the 17-bit compare keeps the carried-out remainder bit.
  always_comb begin
    shifted = {rq, qq[W-1]};
    ge      = shifted >= {1'b0, bq};
    sub     = W'(shifted - {1'b0, bq});
    last    = cnt == CW'(W);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rq        <= '0;
      qq        <= '0;
      bq        <= '0;
      done      <= 1'b0;
      y         <= '0;
      remainder <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rq        <= rq_nxt;
      qq        <= qq_nxt;
      bq        <= bq_nxt;
      done      <= done_nxt;
      y         <= y_nxt;
      remainder <= rem_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_CALC;
      S_CALC:         if (last)  state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values; results publish only on entry to DONE.
  always_comb begin
    cnt_nxt  = cnt;
    rq_nxt   = rq;
    qq_nxt   = qq;
    bq_nxt   = bq;
    done_nxt = done;
    y_nxt    = y;
    rem_nxt  = remainder;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          qq_nxt   = a;
          bq_nxt   = b;
          rq_nxt   = '0;
          cnt_nxt  = '0;
          done_nxt = 1'b0;
        end
      end
      S_CALC: begin
        if (last) begin
          y_nxt    = qq;
          rem_nxt  = rq;
          done_nxt = 1'b1;
        end else begin
          rq_nxt  = ge ? sub : shifted[W-1:0];
          qq_nxt  = {qq[W-2:0], ge};
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Hex digit to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0:    seg7 = 7'b1000000;
      4'h1:    seg7 = 7'b1111001;
      4'h2:    seg7 = 7'b0100100;
      4'h3:    seg7 = 7'b0110000;
      4'h4:    seg7 = 7'b0011001;
      4'h5:    seg7 = 7'b0010010;
      4'h6:    seg7 = 7'b0000010;
      4'h7:    seg7 = 7'b1111000;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0010000;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b0000011;
      4'hC:    seg7 = 7'b1000110;
      4'hD:    seg7 = 7'b0100001;
      4'hE:    seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    out1 = seg7(y[15:12]);
    out2 = seg7(y[11:8]);
    out3 = seg7(y[7:4]);
    out4 = seg7(y[3:0]);
  end

endmodule

// File: tb/tb_div16_seq_led.sv
// Scoreboard bench for div16_seq_led: directed divisions push expected results,
// a monitor pops and compares on every rising edge of done.
module tb_div16_seq_led;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        done;
  logic [15:0] y, remainder;
  logic [6:0]  out1, out2, out3, out4;

  div16_seq_led dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .done(done), .y(y), .remainder(remainder),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] y;
    logic [15:0] rem;
    logic [6:0]  s1, s2, s3, s4;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic done_prev = 1'b0;

  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100,
    D3 = 7'b0110000, D4 = 7'b0011001, D5 = 7'b0010010, D6 = 7'b0000010,
    D7 = 7'b1111000, D8 = 7'b0000000, D9 = 7'b0010000, DA = 7'b0001000,
    DB = 7'b0000011, DC = 7'b1000110, DD = 7'b0100001, DE = 7'b0000110,
    DF = 7'b0001110;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare on each new completed result
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got y=%0h with empty scoreboard", y);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", cyc, e.cyc);
        chk("y", int'(y), int'(e.y));
        chk("remainder", int'(remainder), int'(e.rem));
        chk("out1", int'(out1), int'(e.s1));
        chk("out2", int'(out2), int'(e.s2));
        chk("out3", int'(out3), int'(e.s3));
        chk("out4", int'(out4), int'(e.s4));
      end
    end
    done_prev = done;
  end

  task automatic pulse(input logic [15:0] va, input logic [15:0] vb);
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'h5A5A;
    b = 16'h0003;
  endtask

  task automatic issue(input logic [15:0] va, input logic [15:0] vb,
                       input logic [15:0] ey, input logic [15:0] er,
                       input logic [6:0] s1, input logic [6:0] s2,
                       input logic [6:0] s3, input logic [6:0] s4);
    exp_t e;
    @(negedge clk);
    e.y = ey; e.rem = er; e.s1 = s1; e.s2 = s2; e.s3 = s3; e.s4 = s4;
    e.cyc = cyc + 1 + 17;
    sb.push_back(e);
    a = va;
    b = vb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'h5A5A;
    b = 16'h0003;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [15:0] va, input logic [15:0] vb,
                     input logic [15:0] ey, input logic [15:0] er,
                     input logic [6:0] s1, input logic [6:0] s2,
                     input logic [6:0] s3, input logic [6:0] s4);
    issue(va, vb, ey, er, s1, s2, s3, s4);
    drain();
  endtask

  initial begin
    #12;
    chk("rst_done", int'(done), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_out1", int'(out1), int'(D0));
    chk("rst_out4", int'(out4), int'(D0));
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run(16'd110,   16'd25, 16'd4,      16'd10,  D0, D0, D0, D4);
    run(16'd32200, 16'd37, 16'h0366,   16'd10,  D0, D3, D6, D6);
    chk("done_sticky", int'(done), 1);

    // Start during CALC must be ignored
    issue(16'd1234, 16'd56, 16'h0016, 16'd2, D0, D0, D1, D6);
    repeat (5) @(negedge clk);
    pulse(16'd9, 16'd3);
    drain();
    run(16'd9,     16'd3,  16'd3,      16'd0,   D0, D0, D0, D3);

    run(16'd500,   16'd0,  16'hFFFF,   16'd500, DF, DF, DF, DF);
    chk("b0_done", int'(done), 1);
    run(16'd5,     16'd9,  16'd0,      16'd5,   D0, D0, D0, D0);
    run(16'd0,     16'd5,  16'd0,      16'd0,   D0, D0, D0, D0);
    run(16'hFFFF,  16'd1,  16'hFFFF,   16'd0,   DF, DF, DF, DF);
    run(16'hFFFF,  16'hFFFF, 16'd1,    16'd0,   D0, D0, D0, D1);
    run(16'hABCD,  16'd1,  16'hABCD,   16'd0,   DA, DB, DC, DD);
    run(16'hE895,  16'd1,  16'hE895,   16'd0,   DE, D8, D9, D5);
    run(16'h7247,  16'd1,  16'h7247,   16'd0,   D7, D2, D4, D7);
    run(16'd65000, 16'd300, 16'd216,   16'd200, D0, D0, DD, D8);

    // Reset in the middle of a calculation
    pulse(16'd1000, 16'd7);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_done", int'(done), 0);
    chk("midrst_y", int'(y), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_out3", int'(out3), int'(D0));
    repeat (20) @(negedge clk);
    chk("midrst_hold_done", int'(done), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run(16'd1000,  16'd7,  16'd142,    16'd6,   D0, D0, D8, DE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
